// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, counter widths, pattern encoding and RGB565 colours
// for the 800x480 LCD timing / test-pattern generator.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 32;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_BAR_W              = 100;
    localparam int DEF_FRAMES_PER_PATTERN = 64;

    localparam int H_W = 10;
    localparam int V_W = 10;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GREY  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_WHITE = 2'd3
    } pattern_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

    function automatic pattern_e next_pattern(input pattern_e p);
        case (p)
            PAT_BARS:  return PAT_GREY;
            PAT_GREY:  return PAT_CHECK;
            PAT_CHECK: return PAT_WHITE;
            default:   return PAT_BARS;
        endcase
    endfunction

endpackage

// File: rtl/lcd_timing_pattern_gen_sync_counter.sv
// Horizontal/vertical raster counters with combinational region decode
// (active area, raw sync windows, last pixel of frame).
module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    output logic [H_W-1:0] h_cnt_o,
    output logic [V_W-1:0] v_cnt_o,
    output logic           active_o,
    output logic           hsync_raw_o,
    output logic           vsync_raw_o,
    output logic           frame_end_o
);

    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           h_end, v_end;

    always_comb begin
        h_end   = (h_cnt_q == H_LAST);
        v_end   = (v_cnt_q == V_LAST);
        h_cnt_d = h_end ? '0 : h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_end) begin
            v_cnt_d = v_end ? '0 : v_cnt_q + V_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // VSYNC window depends on the line count only, so it spans whole lines
    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync_raw_o = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vsync_raw_o = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign frame_end_o = h_end && v_end;

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// LCD timing and auto-cycling test-pattern generator; all panel outputs are
// registered one cycle after the raster counters.
//   state     | meaning
//   PAT_BARS  | eight vertical colour bars
//   PAT_GREY  | horizontal grey ramp
//   PAT_CHECK | 32-pixel checkerboard
//   PAT_WHITE | solid white
module lcd_timing_pattern_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE           = DEF_H_ACTIVE,
    parameter int H_FP               = DEF_H_FP,
    parameter int H_SYNC             = DEF_H_SYNC,
    parameter int H_BP               = DEF_H_BP,
    parameter int V_ACTIVE           = DEF_V_ACTIVE,
    parameter int V_FP               = DEF_V_FP,
    parameter int V_SYNC             = DEF_V_SYNC,
    parameter int V_BP               = DEF_V_BP,
    parameter bit HS_POL             = 1'b0,
    parameter bit VS_POL             = 1'b0,
    parameter int BAR_W              = DEF_BAR_W,
    parameter int FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic       pattern_hold,
    output logic       LCD_DE,
    output logic       LCD_HSYNC,
    output logic       LCD_VSYNC,
    output logic [4:0] LCD_R,
    output logic [5:0] LCD_G,
    output logic [4:0] LCD_B,
    output logic [1:0] pattern_idx,
    output logic       frame_start
);

    localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam int BX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [BX_W-1:0] BAR_LAST = BX_W'(BAR_W - 1);
    localparam logic [H_W-1:0]  H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]  H_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    logic [H_W-1:0]  h_cnt;
    logic [V_W-1:0]  v_cnt;
    logic            active, hsync_raw, vsync_raw, frame_end;

    pattern_e        pattern_q;
    logic [FC_W-1:0] frame_cnt_q;
    logic [BX_W-1:0] bar_x_q, bar_x_d;
    logic [2:0]      bar_idx_q, bar_idx_d;

    logic [15:0]     pix, rgb_d, rgb_q;
    logic            hs_d, vs_d, fs_d;
    logic            de_q, hs_q, vs_q, fs_q;
    logic [1:0]      pat_out_q;

    lcd_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk_i       (PixelClk),
        .rst_n_i     (nRST),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .hsync_raw_o (hsync_raw),
        .vsync_raw_o (vsync_raw),
        .frame_end_o (frame_end)
    );

    // pattern_hold only matters on the frame that wraps frame_cnt
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            pattern_q   <= PAT_BARS;
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_q <= '0;
                if (!pattern_hold) begin
                    pattern_q <= next_pattern(pattern_q);
                end
            end else begin
                frame_cnt_q <= frame_cnt_q + FC_W'(1);
            end
        end
    end

    // Bar registers are loaded with the values belonging to the next h_cnt
    always_comb begin
        bar_x_d   = bar_x_q;
        bar_idx_d = bar_idx_q;
        if (h_cnt == H_LAST) begin
            bar_x_d   = '0;
            bar_idx_d = '0;
        end else if (h_cnt < H_ACT) begin
            if (bar_x_q == BAR_LAST) begin
                bar_x_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_x_d = bar_x_q + BX_W'(1);
            end
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            bar_x_q   <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_x_q   <= bar_x_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    always_comb begin
        case (pattern_q)
            PAT_BARS:  pix = bar_colour(bar_idx_q);
            PAT_GREY:  pix = {h_cnt[9:5], h_cnt[9:4], h_cnt[9:5]};
            PAT_CHECK: pix = (h_cnt[5] ^ v_cnt[5]) ? RGB_WHITE : RGB_BLACK;
            default:   pix = RGB_WHITE;
        endcase
        rgb_d = active ? pix : RGB_BLACK;
        hs_d  = hsync_raw ? HS_POL : ~HS_POL;
        vs_d  = vsync_raw ? VS_POL : ~VS_POL;
        fs_d  = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            rgb_q     <= '0;
            fs_q      <= 1'b0;
            pat_out_q <= '0;
        end else begin
            de_q      <= active;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
            pat_out_q <= pattern_q;
        end
    end

    assign LCD_DE      = de_q;
    assign LCD_HSYNC   = hs_q;
    assign LCD_VSYNC   = vs_q;
    assign LCD_R       = rgb_q[15:11];
    assign LCD_G       = rgb_q[10:5];
    assign LCD_B       = rgb_q[4:0];
    assign pattern_idx = pat_out_q;
    assign frame_start = fs_q;

endmodule
